// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store requesters,
// one transaction at a time, data first with a starvation guard for fetch.
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic          owner;
    logic          dm_win;

    always_comb begin
        dm_win    = dm_req && !(if_req && starve == SW'(STARVE_MAX));
        dm_gnt    = state == IDLE && !reset && dm_win;
        if_gnt    = state == IDLE && !reset && if_req && !dm_win;
        dm_rvalid = state == RESP && owner;
        if_rvalid = state == RESP && !owner;
        busy      = state != IDLE;
        state_nx  = state == IDLE   ? ((if_req || dm_req) ? ACCESS : IDLE) :
                    state == ACCESS ? (cnt == '0 ? RESP : ACCESS) : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            starve    <= '0;
            owner     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else if (state == IDLE) begin
            // starve counts data wins that kept a pending fetch waiting
            starve <= (!if_req || if_gnt) ? '0 :
                      (dm_gnt && starve != SW'(STARVE_MAX)) ? starve + SW'(1) : starve;
            if (if_gnt || dm_gnt) begin
                owner     <= dm_gnt;
                mem_en    <= 1'b1;
                mem_we    <= dm_gnt && dm_we;
                mem_addr  <= dm_gnt ? dm_addr : if_addr;
                mem_wdata <= dm_gnt ? dm_wdata : '0;
                cnt       <= CW'(MEM_LAT - 1);
            end
        end else if (state == ACCESS) begin
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end else begin
                mem_en <= 1'b0;
                if (owner && !mem_we) dm_rdata <= mem_rdata;
                if (!owner) if_rdata <= mem_rdata;
            end
        end
    end
endmodule
